uart_rx: RTL and testbench

UART receiver: the receive end of the serial link driven by the team's UART transmitter. Runs on an oversampled clock (baud × OverSample) and synchronizes the asynchronous serial input. It samples each bit at mid-bit, checks optional parity and the stop bit, and pushes each good data word into the RX FIFO through a single-cycle write strobe. With FlowControl enabled, it drives RTS from FIFO fullness so the far-end transmitter can throttle.

---
 rtl/uart_rx_if.sv | 36 +++
 rtl/uart_rx.sv | 165 ++++++++++++++++
 tb/tb_uart_rx.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// UART receiver link bundle: serial line, flow control and RX FIFO push port.
// master = receiver side, slave = line/FIFO side.
interface uart_rx_if #(
    parameter int DataLength = 8
);
    logic                  i_rx;
    logic                  o_rts;
    logic [DataLength-1:0] o_rx_fifo_data;
    logic                  o_rx_fifo_write_en;
    logic                  i_rx_fifo_full;
    logic                  o_parity_err;
    logic                  o_frame_err;
    logic                  o_overrun_err;

    modport master (
        input  i_rx,
        input  i_rx_fifo_full,
        output o_rts,
        output o_rx_fifo_data,
        output o_rx_fifo_write_en,
        output o_parity_err,
        output o_frame_err,
        output o_overrun_err
    );

    modport slave (
        output i_rx,
        output i_rx_fifo_full,
        input  o_rts,
        input  o_rx_fifo_data,
        input  o_rx_fifo_write_en,
        input  o_parity_err,
        input  o_frame_err,
        input  o_overrun_err
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampled UART receiver: mid-bit sampling, optional parity, stop check,
// single-cycle FIFO push and error pulses, RTS driven from FIFO fullness.
module uart_rx #(
    parameter bit ErrorChecking = 1'b0,
    parameter bit ParityEven    = 1'b0,
    parameter int DataLength    = 8,
    parameter int OverSample    = 8,
    parameter bit FlowControl   = 1'b0
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    uart_rx_if.master bus
);
    localparam int CW = $clog2(OverSample);
    localparam int BW = $clog2(DataLength);
    localparam logic [CW-1:0] FULL_BIT = CW'(OverSample - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(OverSample / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DataLength - 1);

    typedef enum logic [2:0] {
        S_RESET,
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_e;

    state_e                r_state;
    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic                  r_rts;
    logic [CW-1:0]         r_clk_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [DataLength-1:0] r_shift;
    logic [DataLength-1:0] r_data;
    logic                  r_par;
    logic                  r_stop;
    logic                  r_brk;
    logic                  r_we;
    logic                  r_perr;
    logic                  r_ferr;
    logic                  r_oerr;
    logic                  w_tick;
    logic                  w_par_ok;

    assign w_tick   = (r_clk_cnt == '0);
    assign w_par_ok = (r_par == ((^r_shift) ^ ~ParityEven));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= bus.i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rts <= 1'b0;
        end else begin
            r_rts <= FlowControl ? ~bus.i_rx_fifo_full : 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_RESET;
            r_clk_cnt <= FULL_BIT;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_par     <= 1'b0;
            r_stop    <= 1'b0;
            r_brk     <= 1'b0;
            r_we      <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_oerr    <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_oerr <= 1'b0;
            unique case (r_state)
                S_RESET: r_state <= S_IDLE;
                // After a framing error the line must go idle before a new start bit counts
                S_IDLE: begin
                    if (r_brk) begin
                        if (r_rx_s) r_brk <= 1'b0;
                    end else if (!r_rx_s) begin
                        r_clk_cnt <= HALF_BIT;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (!w_tick) begin
                        r_clk_cnt <= r_clk_cnt - CW'(1);
                    end else if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_clk_cnt <= FULL_BIT;
                        r_bit_cnt <= '0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!w_tick) begin
                        r_clk_cnt <= r_clk_cnt - CW'(1);
                    end else begin
                        r_shift[r_bit_cnt] <= r_rx_s;
                        r_clk_cnt          <= FULL_BIT;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= ErrorChecking ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (!w_tick) begin
                        r_clk_cnt <= r_clk_cnt - CW'(1);
                    end else begin
                        r_par     <= r_rx_s;
                        r_clk_cnt <= FULL_BIT;
                        r_state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (!w_tick) begin
                        r_clk_cnt <= r_clk_cnt - CW'(1);
                    end else begin
                        r_stop  <= r_rx_s;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    if (!r_stop) begin
                        r_ferr <= 1'b1;
                        r_brk  <= 1'b1;
                    end else if (ErrorChecking && !w_par_ok) begin
                        r_perr <= 1'b1;
                    end else if (bus.i_rx_fifo_full) begin
                        r_oerr <= 1'b1;
                    end else begin
                        r_we   <= 1'b1;
                        r_data <= r_shift;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_rts              = r_rts;
    assign bus.o_rx_fifo_data     = r_data;
    assign bus.o_rx_fifo_write_en = r_we;
    assign bus.o_parity_err       = r_perr;
    assign bus.o_frame_err        = r_ferr;
    assign bus.o_overrun_err      = r_oerr;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 receiver and an 8E1 flow-controlled receiver,
// checked against a frame-level reference model with timed event queues.
module tb_uart_rx;
    localparam int OS    = 8;
    localparam int K_WR  = 0;
    localparam int K_PAR = 1;
    localparam int K_FRM = 2;
    localparam int K_OVR = 3;

    typedef struct {
        bit         sel;
        int         kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    typedef struct {
        bit         sel;
        logic [7:0] d;
        bit         pbit;
        bit         stop;
        bit         full;
        int         gap;
        int         kind;
    } vec_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rx_a   = 1'b1;
    logic rx_b   = 1'b1;
    logic full_a = 1'b0;
    logic full_b = 1'b0;
    int   cyc    = 0;
    int   total  = 0;
    int   bad    = 0;
    ev_t  expq[$];
    ev_t  obsq[$];

    uart_rx_if #(.DataLength(8)) ifa ();
    uart_rx_if #(.DataLength(8)) ifb ();

    assign ifa.i_rx           = rx_a;
    assign ifa.i_rx_fifo_full = full_a;
    assign ifb.i_rx           = rx_b;
    assign ifb.i_rx_fifo_full = full_b;

    uart_rx #(
        .ErrorChecking(1'b0), .ParityEven(1'b0), .DataLength(8),
        .OverSample(OS), .FlowControl(1'b0)
    ) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(ifa));

    uart_rx #(
        .ErrorChecking(1'b1), .ParityEven(1'b1), .DataLength(8),
        .OverSample(OS), .FlowControl(1'b1)
    ) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk_ev(bit sel, int kind, logic [7:0] d);
        ev_t e;
        e.sel  = sel;
        e.kind = kind;
        e.data = d;
        e.cyc  = cyc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (ifa.o_rx_fifo_write_en) obsq.push_back(mk_ev(1'b0, K_WR, ifa.o_rx_fifo_data));
        if (ifa.o_parity_err)       obsq.push_back(mk_ev(1'b0, K_PAR, 8'h00));
        if (ifa.o_frame_err)        obsq.push_back(mk_ev(1'b0, K_FRM, 8'h00));
        if (ifa.o_overrun_err)      obsq.push_back(mk_ev(1'b0, K_OVR, 8'h00));
        if (ifb.o_rx_fifo_write_en) obsq.push_back(mk_ev(1'b1, K_WR, ifb.o_rx_fifo_data));
        if (ifb.o_parity_err)       obsq.push_back(mk_ev(1'b1, K_PAR, 8'h00));
        if (ifb.o_frame_err)        obsq.push_back(mk_ev(1'b1, K_FRM, 8'h00));
        if (ifb.o_overrun_err)      obsq.push_back(mk_ev(1'b1, K_OVR, 8'h00));
    end

    // Frame outcome from the line-level rules: stop, then even parity, then FIFO space.
    function automatic int ref_kind(bit sel, logic [7:0] d, bit pbit, bit stop, bit full);
        if (!stop) return K_FRM;
        if (sel && (pbit != (^d))) return K_PAR;
        if (full) return K_OVR;
        return K_WR;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setrx(input bit sel, input logic v);
        if (sel) rx_b = v;
        else rx_a = v;
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit pbit,
                        input bit stop, input bit full, input int gap, input int kind);
        logic fr[$];
        ev_t  e;
        fr.push_back(1'b0);
        for (int i = 0; i < 8; i++) fr.push_back(d[i]);
        if (sel) fr.push_back(pbit);
        fr.push_back(stop);
        e.sel  = sel;
        e.kind = kind;
        e.data = d;
        e.cyc  = cyc + OS * fr.size();
        expq.push_back(e);
        if (sel) full_b = full;
        else full_a = full;
        foreach (fr[i]) begin
            setrx(sel, fr[i]);
            wait_cyc(OS);
        end
        setrx(sel, 1'b1);
        if (gap > 0) wait_cyc(gap);
        if (sel) full_b = 1'b0;
        else full_a = 1'b0;
    endtask

    task automatic drain();
        ev_t e;
        ev_t o;
        while (expq.size() > 0) begin
            e = expq.pop_front();
            if (obsq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL missing_event: got none want dut %0d kind %0d at cyc %0d",
                         e.sel, e.kind, e.cyc);
            end else begin
                o = obsq.pop_front();
                chk("ev_dut", 32'(o.sel), 32'(e.sel));
                chk("ev_kind", o.kind, e.kind);
                chk("ev_cyc", o.cyc, e.cyc);
                if (e.kind == K_WR) chk("ev_data", 32'(o.data), 32'(e.data));
            end
        end
        while (obsq.size() > 0) begin
            o = obsq.pop_front();
            total++;
            bad++;
            $display("FAIL extra_event: got dut %0d kind %0d at cyc %0d want none",
                     o.sel, o.kind, o.cyc);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rts_a"}, 32'(ifa.o_rts), 0);
        chk({tag, "_data_a"}, 32'(ifa.o_rx_fifo_data), 0);
        chk({tag, "_we_a"}, 32'(ifa.o_rx_fifo_write_en), 0);
        chk({tag, "_errs_a"}, 32'({ifa.o_parity_err, ifa.o_frame_err, ifa.o_overrun_err}), 0);
        chk({tag, "_rts_b"}, 32'(ifb.o_rts), 0);
        chk({tag, "_data_b"}, 32'(ifb.o_rx_fifo_data), 0);
        chk({tag, "_we_b"}, 32'(ifb.o_rx_fifo_write_en), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish want finish by 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       tbl[11];
        logic [7:0] d;
        bit         sel, pbit, stop, full;
        int         gap;

        tbl[0]  = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 4, K_WR};
        tbl[1]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 4, K_WR};
        tbl[2]  = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 4, K_PAR};
        tbl[3]  = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 16, K_FRM};
        tbl[4]  = '{1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 4, K_WR};
        tbl[5]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 16, K_FRM};
        tbl[6]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 4, K_PAR};
        tbl[7]  = '{1'b0, 8'h81, 1'b0, 1'b1, 1'b1, 4, K_OVR};
        tbl[8]  = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 2, K_WR};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, K_WR};
        tbl[10] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 4, K_WR};

        @(negedge clk);
        chk_reset_outs("por");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cyc(2);
        chk("rts_a_after_reset", 32'(ifa.o_rts), 1);
        chk("rts_b_after_reset", 32'(ifb.o_rts), 1);

        for (int i = 0; i < 11; i++) begin
            send(tbl[i].sel, tbl[i].d, tbl[i].pbit, tbl[i].stop,
                 tbl[i].full, tbl[i].gap, tbl[i].kind);
        end
        drain();

        // Short low glitch must not start a frame
        rx_a = 1'b0;
        wait_cyc(3);
        rx_a = 1'b1;
        wait_cyc(16);
        send(1'b0, 8'h81, 1'b0, 1'b1, 1'b0, 4, K_WR);
        drain();

        // Break: one framing error, then nothing until the line is high again
        expq.push_back('{1'b0, K_FRM, 8'h00, cyc + 10 * OS});
        rx_a = 1'b0;
        wait_cyc(240);
        rx_a = 1'b1;
        wait_cyc(16);
        send(1'b0, 8'h96, 1'b0, 1'b1, 1'b0, 4, K_WR);
        drain();

        // RTS follows FIFO fullness one cycle late
        full_b = 1'b1;
        @(negedge clk);
        chk("rts_b_hold", 32'(ifb.o_rts), 1);
        wait_cyc(1);
        chk("rts_b_full", 32'(ifb.o_rts), 0);
        send(1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 4, K_OVR);
        @(negedge clk);
        chk("rts_b_still0", 32'(ifb.o_rts), 0);
        wait_cyc(1);
        chk("rts_b_release", 32'(ifb.o_rts), 1);
        drain();

        for (int n = 0; n < 24; n++) begin
            sel  = 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            pbit = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 7) != 0);
            full = ($urandom_range(0, 3) == 0);
            gap  = stop ? $urandom_range(0, 3) : 12;
            send(sel, d, pbit, stop, full, gap, ref_kind(sel, d, pbit, stop, full));
        end
        wait_cyc(4);
        drain();

        // Back-to-back frames, then reset in the middle of a third
        send(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 0, K_WR);
        send(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, K_WR);
        rx_a = 1'b0;
        wait_cyc(OS);
        rx_a = 1'b1;
        wait_cyc(OS);
        rx_a = 1'b0;
        wait_cyc(4);
        rst_n = 1'b0;
        rx_a  = 1'b1;
        @(negedge clk);
        chk_reset_outs("midrst");
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(4);
        chk("rts_a_after_midrst", 32'(ifa.o_rts), 1);
        drain();
        send(1'b0, 8'h12, 1'b0, 1'b1, 1'b0, 4, K_WR);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
